// File: rtl/sr_mod_counter_pkg.sv
// Shared SR-cell encoding and excitation helper for the modulo counter.
package sr_cnt_pkg;

    // {s, r} pairs presented to an SR cell
    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    function automatic logic [1:0] sr_enc(input logic q_i, input logic n_i);
        logic [1:0] sr;
        sr = SR_HOLD;
        if (!q_i && n_i)
            sr = SR_SET;
        else if (q_i && !n_i)
            sr = SR_RST;
        return sr;
    endfunction

endpackage

// File: rtl/sr_mod_counter_sr_cell.sv
// One-bit SR flip-flop with async active-high reset to a per-instance value.
module sr_cell
    import sr_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_d, q_q;

    // s = r = 1 is treated as hold so the bit never goes unknown
    always_comb begin
        q_d = q_q;
        case ({s, r})
            SR_SET:  q_d = 1'b1;
            SR_RST:  q_d = 1'b0;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= rst_val;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sr_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter built from SR cells with load, tc and wrap.
// Define SR_MOD_COUNTER_SR_CHECK_EN to add the sticky err output flagging s=r=1 on any bit.
module sr_mod_counter
    import sr_cnt_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
`ifdef SR_MOD_COUNTER_SR_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   q_ext, inc_ext;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] s_vec, r_vec;
    logic             wrap_d, wrap_q, load_err_d, load_err_q;

    assign q_ext = {1'b0, q};

    // Extra top bit keeps MODULUS = 2^WIDTH comparable without truncation
    always_comb begin
        nxt        = q;
        inc_ext    = q_ext + 1'b1;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                nxt = load_val;
            end else begin
                nxt        = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (inc_ext == MOD_W) begin
                    nxt    = '0;
                    wrap_d = 1'b1;
                end else begin
                    nxt = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (q == '0) begin
                    nxt    = MOD_M1;
                    wrap_d = 1'b1;
                end else begin
                    nxt = q - 1'b1;
                end
            end
        end
    end

    assign tc = en & ~load & ((up & (q_ext == MOD_W - 1'b1)) | (~up & (q == '0)));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {s_vec[i], r_vec[i]} = sr_enc(q[i], nxt[i]);
        sr_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_V[i]),
            .s       (s_vec[i]),
            .r       (r_vec[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap     = wrap_q;
    assign load_err = load_err_q;

`ifdef SR_MOD_COUNTER_SR_CHECK_EN
    logic err_d, err_q;

    assign err_d = err_q | (|(s_vec & r_vec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_sr_mod_counter.sv
// Directed scoreboard bench for sr_mod_counter (MODULUS 10 and power-of-two instances).
module tb_sr_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst16 = 1'b1;
    logic         en = 1'b0, up = 1'b1, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q, q16;
    logic         tc, wrap, lerr, tc16, wrap16, lerr16;
`ifdef SR_MOD_COUNTER_SR_CHECK_EN
    logic         err, err16;
`endif

    int           n_cmp = 0;
    int           n_err = 0;
    bit           mon_off = 1'b0;
    int           m_q = 0;
    logic [W+1:0] sb[$];

    always #5 clk = ~clk;

    sr_mod_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q), .tc(tc), .wrap(wrap), .load_err(lerr)
`ifdef SR_MOD_COUNTER_SR_CHECK_EN
        , .err(err)
`endif
    );

    sr_mod_counter #(.WIDTH(W), .MODULUS(16), .RESET_VAL(15)) dut16 (
        .clk(clk), .rst(rst16), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q16), .tc(tc16), .wrap(wrap16), .load_err(lerr16)
`ifdef SR_MOD_COUNTER_SR_CHECK_EN
        , .err(err16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // s and r must never be asserted together on any bit
    always @(negedge clk) begin
        if (!mon_off) begin
            check("sr_excl", 32'(dut.s_vec & dut.r_vec), 32'd0);
            check("sr_excl16", 32'(dut16.s_vec & dut16.r_vec), 32'd0);
        end
    end

    task automatic pop_compare();
        logic [W+1:0] e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL sb_empty: observed %0d expected %0d", 0, 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", 32'(q), 32'(e[W+1:2]));
            check("wrap", 32'(wrap), 32'(e[1]));
            check("load_err", 32'(lerr), 32'(e[0]));
        end
    endtask

    task automatic step(input logic e, input logic u, input logic l, input int lv);
        logic [W-1:0] nq;
        logic         w, le, etc;
        @(negedge clk);
        en = e; up = u; load = l; load_val = W'(lv);
        #1;
        etc = e & ~l & ((u && m_q == MOD-1) || (!u && m_q == 0));
        check("tc", 32'(tc), 32'(etc));
        nq = W'(m_q); w = 1'b0; le = 1'b0;
        if (l) begin
            if (lv < MOD) nq = W'(lv);
            else begin nq = '0; le = 1'b1; end
        end else if (e) begin
            if (u) begin
                if (m_q == MOD-1) begin nq = '0; w = 1'b1; end
                else nq = W'(m_q + 1);
            end else begin
                if (m_q == 0) begin nq = W'(MOD-1); w = 1'b1; end
                else nq = W'(m_q - 1);
            end
        end
        sb.push_back({nq, w, le});
        m_q = int'(nq);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    initial begin
        en = 1'b1; up = 1'b1;
        #12;
        check("rst_q", 32'(q), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_lerr", 32'(lerr), 32'd0);
        check("rst_q16", 32'(q16), 32'd15);
        check("rst_wrap16", 32'(wrap16), 32'd0);
        check("rst_lerr16", 32'(lerr16), 32'd0);
        check("rst_tc16", 32'(tc16), 32'd1);

        // power-of-two modulus: first edge after release wraps 15 -> 0
        @(negedge clk); rst16 = 1'b0;
        @(posedge clk); #1;
        check("p2_q", 32'(q16), 32'd0);
        check("p2_wrap", 32'(wrap16), 32'd1);
        check("held_q", 32'(q), 32'd0);
        @(posedge clk); #1;
        check("p2_q_next", 32'(q16), 32'd1);
        check("p2_wrap_next", 32'(wrap16), 32'd0);

        @(negedge clk); rst = 1'b0; en = 1'b0; m_q = 0;
        repeat (3) step(1, 1, 0, 0);

        // async reset mid-count
        @(posedge clk); #3; rst = 1'b1; #1;
        check("async_q", 32'(q), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        @(negedge clk); en = 1'b0; rst = 1'b0; m_q = 0;
        step(0, 1, 0, 0);

        repeat (12) step(1, 1, 0, 0);

        step(0, 0, 1, 3);
        repeat (5) step(1, 0, 0, 0);

        step(1, 1, 1, 7);
        step(1, 1, 1, 12);
        step(0, 1, 0, 0);
        step(0, 0, 1, 9);
        step(0, 0, 1, 10);

        repeat (5) step(0, 1, 0, 0);

        step(0, 1, 1, 5);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

`ifdef SR_MOD_COUNTER_SR_CHECK_EN
        check("err_clean", 32'(err), 32'd0);
        check("err16_clean", 32'(err16), 32'd0);
        mon_off = 1'b1;
        @(negedge clk); en = 1'b0; load = 1'b0;
        force dut.s_vec = 4'b0001;
        force dut.r_vec = 4'b0001;
        @(posedge clk); #1;
        release dut.s_vec;
        release dut.r_vec;
        check("err_set", 32'(err), 32'd1);
        check("err_hold_q", 32'(q), 32'(m_q));
        @(negedge clk); mon_off = 1'b0;
        @(posedge clk); #1;
        check("err_sticky", 32'(err), 32'd1);
        rst = 1'b1; #1;
        check("err_clr", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0; m_q = 0;
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_mod_counter.md
Name: sr_mod_counter

Overview:
- Parametrised successor to the 4-bit SR-flip-flop loadable counter that feeds the BCD/7-segment display path.
- Provides a WIDTH-bit, modulo-MODULUS up/down counter with synchronous parallel load, count enable, terminal-count and wrap flags.
- Every state bit is held in an SR cell driven by excitation logic (s = set-needed, r = reset-needed); no D-register shortcut.
- Output q feeds binary_to_BCD / hex_7seg directly.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- RESET_VAL, 0, value forced by rst; must be < MODULUS.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable.
- up  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load, active-high.
- load_val  input  WIDTH  value taken on load.
- q  output  WIDTH  current count.
- tc  output  1  combinational terminal-count flag.
- wrap  output  1  registered one-cycle pulse marking that a wrap occurred.
- load_err  output  1  registered one-cycle pulse marking a rejected load value.

Behaviour:
- Reset and clocking: one clock (clk); reset rst is asynchronous, active-high.
- While rst = 1: q = RESET_VAL, wrap = 0, load_err = 0, err = 0. Release is synchronous to the next rising edge of clk.
- Priority per edge: rst > load > en > hold.
- load = 1, load_val < MODULUS: q <= load_val; wrap <= 0; load_err <= 0. The up and en inputs are ignored.
- load = 1, load_val >= MODULUS: q <= 0; load_err <= 1 for one cycle.
- en = 1, up = 1: q <= q+1. If q = MODULUS-1, then q <= 0 and wrap <= 1.
- en = 1, up = 0: q <= q-1. If q = 0, then q <= MODULUS-1 and wrap <= 1.
- en = 0, load = 0: q holds; wrap <= 0; load_err <= 0.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)). tc is high in the cycle before the wrap edge.
- Latency: q updates one edge after a qualifying en or load. wrap and load_err are registered, so they are visible one cycle after the causing edge, coincident with the new q.
- Excitation per bit i, with n = next-state bit:
  - s_i = ~q_i & n_i
  - r_i = q_i & ~n_i
  - Both are 0 when the bit holds.
  - s_i & r_i must never both be 1.
- Next-state arithmetic is WIDTH+1 bits wide internally, with no truncation before the modulus compare.
- MODULUS = 2^WIDTH degenerates to natural binary wrap; the flags still behave as specified.
- Changing up in the same cycle as en is legal; direction is sampled at the edge.
- rst asserted mid-count aborts the count immediately (asynchronous); no pulse is emitted on release.

Optional Feature:
- Macro: SR_MOD_COUNTER_SR_CHECK_EN.
- Defined:
  - Adds output port err (1 bit), sticky, cleared only by rst.
  - err sets on the edge at which any bit has s_i & r_i = 1.
  - The affected bit holds its value rather than going X.
- Undefined:
  - No err port and no check logic.
  - The illegal s=r=1 case is unreachable by construction; the SR cell treats it as hold.

Decomposition:
- Package sr_cnt_pkg holds:
  - SR-cell input encoding constants SR_HOLD, SR_RST, SR_SET, SR_ILLEGAL.
  - A function that computes the {s, r} pair from (q_i, n_i).
- Sub-module sr_cell:
  - One-bit SR flip-flop with asynchronous active-high reset to a per-instance reset bit.
  - Ports: clk, rst, rst_val, s, r, q.
  - Instantiated WIDTH times via generate.

Test Plan (WIDTH = 4, MODULUS = 10 unless noted):
- Reset and count up: rst pulse mid-count -> q = 0 asynchronously. Then en = 1, up = 1 for 12 cycles -> q = 1..9, 0, 1, 2; tc high while q = 9; wrap high exactly one cycle, with q = 0.
- Count down: load 3, then en = 1, up = 0 -> q = 2, 1, 0, 9, 8; wrap pulse coincident with q = 9; tc high while q = 0.
- Load priority: load = 1, load_val = 7 with en = 1 -> q = 7, no wrap. Then load_val = 12 -> q = 0, load_err pulses once.
- Hold and direction change: en = 0 for 5 cycles -> q constant, tc = 0. Flip up at each edge from q = 5 -> q = 6, 5, 6.
- Power-of-two modulus (MODULUS = 16, RESET_VAL = 15): release rst with en = 1, up = 1 -> q = 0 on the first edge, wrap pulses.
- Excitation monitor across all scenarios: s_i & r_i never both 1. With SR_MOD_COUNTER_SR_CHECK_EN defined, err stays 0; forcing s_0 = r_0 = 1 via force -> err = 1 sticky until rst.
